// File: rtl/door_pkg.sv
// Shared encodings for the sliding door controller.
// State codes, mode codes and the state-to-motor mapping.
package door_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_OPENING = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_CLOSING = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    localparam logic [1:0] MODE_AUTO        = 2'b00;
    localparam logic [1:0] MODE_LOCK_OPEN   = 2'b01;
    localparam logic [1:0] MODE_LOCK_CLOSED = 2'b10;

    // Motor command {mo, mc, ms} driven while in a given state.
    function automatic logic [2:0] motor_bits(input logic [2:0] st);
        logic [2:0] m;
        m = 3'b000;
        case (st)
            ST_OPENING: m = 3'b100;
            ST_CLOSING: m = 3'b010;
            ST_STOP:    m = 3'b001;
            ST_FAULT:   m = 3'b001;
            default:    m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable saturating up/down counter used for hold and travel timing.
// Ports: clk, rst (async low), clr, load/load_val, up, dn -> count.
module door_timer #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] TOP = W'(MAX);
    localparam logic [W-1:0] ONE = W'(1);

    // Priority: clear, load, count up, count down; both ends saturate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (up && count != TOP) begin
            count <= count + ONE;
        end else if (dn && count != '0) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/sliding_door_ctrl.sv
// Automatic sliding door controller: open on presence, hold, close, reverse on obstruction, fault on timeout or switch conflict.
// Ports: clk, rst (async low), person_detected, door_opened, door_closed, mode[1:0], fault_clr -> mo, mc, ms, fault, obstr_alarm, state_o[2:0].
module sliding_door_ctrl
    import door_pkg::*;
#(
    parameter int HOLD_CYCLES    = 15,
    parameter int TRAVEL_TIMEOUT = 64,
    parameter int MAX_REOPEN     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       person_detected,
    input  logic       door_opened,
    input  logic       door_closed,
    input  logic [1:0] mode,
    input  logic       fault_clr,
    output logic       mo,
    output logic       mc,
    output logic       ms,
    output logic       fault,
    output logic       obstr_alarm,
    output logic [2:0] state_o
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TRAVEL_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_REOPEN + 1);

    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
    localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_TIMEOUT - 1);
    localparam logic [RW-1:0] ROP_MAX   = RW'(MAX_REOPEN);
    localparam logic [RW-1:0] ROP_ONE   = RW'(1);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] trav_cnt;
    logic [RW-1:0] rop_q;
    logic [RW-1:0] rop_d;
    logic          alarm_q;
    logic          alarm_d;

    logic hold_ld;
    logic hold_dn;
    logic trav_clr;
    logic trav_up;
    logic cnt_clr;

    logic lock_open;
    logic lock_closed;
    logic auto_m;
    logic conflict;
    logic trav_exp;
    logic person_eff;

    assign lock_open   = (mode == MODE_LOCK_OPEN);
    assign lock_closed = (mode == MODE_LOCK_CLOSED);
    assign auto_m      = !lock_open && !lock_closed;
    assign conflict    = door_opened && door_closed;
    // The current cycle is the last allowed one in travel.
    assign trav_exp    = (trav_cnt >= TRAV_LAST);
    // Presence does not extend the hold while locked closed.
    assign person_eff  = person_detected && !lock_closed;

    always_comb begin
        state_d  = state_q;
        hold_ld  = 1'b0;
        hold_dn  = 1'b0;
        trav_clr = 1'b0;
        trav_up  = 1'b0;
        cnt_clr  = 1'b0;
        rop_d    = rop_q;
        alarm_d  = alarm_q;
        if (conflict && state_q inside
            {ST_IDLE, ST_OPENING, ST_OPEN, ST_CLOSING, ST_STOP}) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lock_open ||
                        (auto_m && person_detected && door_closed)) begin
                        state_d  = ST_OPENING;
                        trav_clr = 1'b1;
                    end
                end
                ST_OPENING: begin
                    if (door_opened) begin
                        state_d = ST_OPEN;
                        hold_ld = 1'b1;
                    end else if (trav_exp) begin
                        state_d = ST_FAULT;
                    end else begin
                        trav_up = 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (person_eff) begin
                        hold_ld = 1'b1;
                    end else if (hold_cnt != '0) begin
                        hold_dn = 1'b1;
                    end else if (!lock_open) begin
                        state_d  = ST_CLOSING;
                        trav_clr = 1'b1;
                    end
                end
                ST_CLOSING: begin
                    // A lock-open request reverses without counting as an obstruction.
                    if (lock_open) begin
                        state_d  = ST_OPENING;
                        trav_clr = 1'b1;
                    end else if (person_detected) begin
                        state_d = ST_STOP;
                        if (rop_q != ROP_MAX) begin
                            rop_d = rop_q + ROP_ONE;
                        end
                    end else if (door_closed) begin
                        state_d = ST_IDLE;
                        rop_d   = '0;
                        alarm_d = 1'b0;
                    end else if (trav_exp) begin
                        state_d = ST_FAULT;
                    end else begin
                        trav_up = 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!person_detected) begin
                        state_d  = ST_OPENING;
                        trav_clr = 1'b1;
                        if (rop_q == ROP_MAX) begin
                            alarm_d = 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                        rop_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    door_timer #(
        .W   (HW),
        .MAX (HOLD_CYCLES)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (hold_ld),
        .load_val (HOLD_INIT),
        .up       (1'b0),
        .dn       (hold_dn),
        .count    (hold_cnt)
    );

    door_timer #(
        .W   (TW),
        .MAX (TRAVEL_TIMEOUT)
    ) u_trav (
        .clk      (clk),
        .rst      (rst),
        .clr      (trav_clr | cnt_clr),
        .load     (1'b0),
        .load_val ('0),
        .up       (trav_up),
        .dn       (1'b0),
        .count    (trav_cnt)
    );

    // Outputs follow the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            {mo, mc, ms} <= 3'b000;
            fault        <= 1'b0;
            rop_q        <= '0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            {mo, mc, ms} <= motor_bits(state_d);
            fault        <= (state_d == ST_FAULT);
            rop_q        <= rop_d;
            alarm_q      <= alarm_d;
        end
    end

    assign state_o     = state_q;
    assign obstr_alarm = alarm_q;

endmodule

// File: tb/tb_sliding_door_ctrl.sv
// Self-checking bench for sliding_door_ctrl: directed scenarios then random stimulus.
// Every cycle is compared against a behavioural door model.
module tb_sliding_door_ctrl;
    import door_pkg::*;

    localparam int HOLD = 4;
    localparam int TRAV = 8;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       person_detected = 1'b0;
    logic       door_opened = 1'b0;
    logic       door_closed = 1'b0;
    logic [1:0] mode = MODE_AUTO;
    logic       fault_clr = 1'b0;
    logic       mo, mc, ms, fault, obstr_alarm;
    logic [2:0] state_o;

    int n_chk = 0;
    int n_err = 0;

    sliding_door_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .TRAVEL_TIMEOUT (TRAV),
        .MAX_REOPEN     (MAXR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .person_detected (person_detected),
        .door_opened     (door_opened),
        .door_closed     (door_closed),
        .mode            (mode),
        .fault_clr       (fault_clr),
        .mo              (mo),
        .mc              (mc),
        .ms              (ms),
        .fault           (fault),
        .obstr_alarm     (obstr_alarm),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    typedef enum {
        M_IDLE, M_OPENING, M_OPEN, M_CLOSING, M_STOP, M_FAULT
    } mst_t;

    mst_t m_st;
    int   m_hold;
    int   m_trav;
    int   m_rop;
    bit   m_alarm;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void mreset();
        m_st    = M_IDLE;
        m_hold  = 0;
        m_trav  = 0;
        m_rop   = 0;
        m_alarm = 0;
    endfunction

    // One clock of door behaviour, written from the rule list.
    function automatic void mstep();
        bit p, lo, lc;
        p  = person_detected;
        lo = (mode == 2'b01);
        lc = (mode == 2'b10);
        if (m_st != M_FAULT && door_opened && door_closed) begin
            m_st = M_FAULT;
            return;
        end
        case (m_st)
            M_IDLE:
                if (lo || (!lo && !lc && p && door_closed)) begin
                    m_st = M_OPENING;
                    m_trav = 0;
                end
            M_OPENING:
                if (door_opened) begin
                    m_st = M_OPEN;
                    m_hold = HOLD;
                end else begin
                    m_trav++;
                    if (m_trav >= TRAV) m_st = M_FAULT;
                end
            M_OPEN:
                if (p && !lc) m_hold = HOLD;
                else if (m_hold > 0) m_hold--;
                else if (!lo) begin
                    m_st = M_CLOSING;
                    m_trav = 0;
                end
            M_CLOSING:
                if (lo) begin
                    m_st = M_OPENING;
                    m_trav = 0;
                end else if (p) begin
                    m_st = M_STOP;
                    m_rop = (m_rop < MAXR) ? m_rop + 1 : MAXR;
                end else if (door_closed) begin
                    m_st = M_IDLE;
                    m_rop = 0;
                    m_alarm = 0;
                end else begin
                    m_trav++;
                    if (m_trav >= TRAV) m_st = M_FAULT;
                end
            M_STOP:
                if (!p) begin
                    if (m_rop == MAXR) m_alarm = 1;
                    m_st = M_OPENING;
                    m_trav = 0;
                end
            M_FAULT:
                if (fault_clr) begin
                    m_st = M_IDLE;
                    m_hold = 0;
                    m_trav = 0;
                    m_rop = 0;
                end
            default: m_st = M_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] mcode();
        case (m_st)
            M_OPENING: return ST_OPENING;
            M_OPEN:    return ST_OPEN;
            M_CLOSING: return ST_CLOSING;
            M_STOP:    return ST_STOP;
            M_FAULT:   return ST_FAULT;
            default:   return ST_IDLE;
        endcase
    endfunction

    task automatic cmp_model();
        chk("m_state", state_o, mcode());
        chk("m_mo", mo, (m_st == M_OPENING) ? 1 : 0);
        chk("m_mc", mc, (m_st == M_CLOSING) ? 1 : 0);
        chk("m_ms", ms, (m_st == M_STOP || m_st == M_FAULT) ? 1 : 0);
        chk("m_fault", fault, (m_st == M_FAULT) ? 1 : 0);
        chk("m_alarm", obstr_alarm, m_alarm);
    endtask

    task automatic cyc();
        @(posedge clk);
        mstep();
        #1;
        cmp_model();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o != s && n < budget) begin
            cyc();
            n++;
        end
        chk("wait_state", state_o, s);
    endtask

    // From IDLE in AUTO: open fully, then ride the hold into CLOSING.
    task automatic to_closing();
        door_opened = 1'b0;
        door_closed = 1'b1;
        person_detected = 1'b1;
        cyc();
        person_detected = 1'b0;
        door_closed = 1'b0;
        door_opened = 1'b1;
        cyc();
        wait_state(ST_CLOSING, 20);
        door_opened = 1'b0;
    endtask

    initial begin
        int n;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_o, ST_IDLE);
        chk("rst_motors", {mo, mc, ms}, 0);
        chk("rst_fault", fault, 0);
        chk("rst_alarm", obstr_alarm, 0);
        rst = 1'b1;
        door_closed = 1'b1;
        cyc();

        // Basic open / hold / close cycle.
        person_detected = 1'b1;
        cyc();
        chk("r32_mo", mo, 1);
        person_detected = 1'b0;
        door_closed = 1'b0;
        repeat (4) cyc();
        door_opened = 1'b1;
        cyc();
        chk("r32_open", state_o, ST_OPEN);
        n = 0;
        while (mc == 1'b0 && n < 20) begin
            cyc();
            n++;
        end
        chk("r32_hold", n, 5);
        door_opened = 1'b0;
        door_closed = 1'b1;
        cyc();
        chk("r32_idle", state_o, ST_IDLE);
        chk("r32_motors", {mo, mc, ms}, 0);

        // Presence at hold==1 reloads the hold.
        person_detected = 1'b1;
        cyc();
        person_detected = 1'b0;
        door_closed = 1'b0;
        cyc();
        door_opened = 1'b1;
        cyc();
        repeat (3) cyc();
        person_detected = 1'b1;
        cyc();
        person_detected = 1'b0;
        n = 0;
        while (mc == 1'b0 && n < 20) begin
            cyc();
            n++;
        end
        chk("r33_reload", n, 5);
        door_opened = 1'b0;

        // Repeated obstructions raise the alarm.
        for (int i = 0; i < 3; i++) begin
            person_detected = 1'b1;
            cyc();
            chk("r34_ms", ms, 1);
            person_detected = 1'b0;
            cyc();
            chk("r34_mo", mo, 1);
            chk("r34_alarm", obstr_alarm, (i >= 1) ? 1 : 0);
            door_opened = 1'b1;
            cyc();
            wait_state(ST_CLOSING, 20);
            door_opened = 1'b0;
        end
        door_closed = 1'b1;
        cyc();
        chk("r34_idle", state_o, ST_IDLE);
        chk("r34_clr", obstr_alarm, 0);

        // Opening never reaches the limit switch.
        person_detected = 1'b1;
        cyc();
        person_detected = 1'b0;
        door_closed = 1'b0;
        n = 0;
        while (fault == 1'b0 && n < 20) begin
            cyc();
            n++;
        end
        chk("r35_tmo", n, 8);
        chk("r35_ms", ms, 1);
        fault_clr = 1'b1;
        cyc();
        chk("r35_clr", state_o, ST_IDLE);
        chk("r35_fault", fault, 0);
        fault_clr = 1'b0;

        // Switch conflict while open.
        door_closed = 1'b1;
        person_detected = 1'b1;
        cyc();
        person_detected = 1'b0;
        door_closed = 1'b0;
        door_opened = 1'b1;
        cyc();
        chk("r36_open", state_o, ST_OPEN);
        door_closed = 1'b1;
        cyc();
        chk("r36_conf", state_o, ST_FAULT);
        door_closed = 1'b0;
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;

        // Asynchronous reset in the middle of closing.
        to_closing();
        cyc();
        rst = 1'b0;
        #1;
        mreset();
        chk("r36_rst_st", state_o, ST_IDLE);
        chk("r36_rst_mot", {mo, mc, ms}, 0);
        cmp_model();
        #2;
        rst = 1'b1;

        // Lock-open during closing.
        to_closing();
        mode = MODE_LOCK_OPEN;
        cyc();
        chk("r37_reopen", state_o, ST_OPENING);
        door_opened = 1'b1;
        cyc();
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("r37_hold", state_o, ST_OPEN);
            chk("r37_mot", {mo, mc, ms}, 0);
        end
        mode = MODE_AUTO;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            person_detected = ($urandom_range(0, 99) < 25);
            door_opened     = ($urandom_range(0, 99) < 15);
            door_closed     = ($urandom_range(0, 99) < 15);
            fault_clr       = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 3)
                mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                #1;
                mreset();
                cmp_model();
                #1;
                rst = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sliding_door_ctrl.md
SLIDING_DOOR_CTRL -- requirements
Module: sliding_door_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 15, open-hold time in clocks after last person detection.
REQ-002 SHALL have parameter TRAVEL_TIMEOUT, default 64, max clocks allowed in OPENING or CLOSING before fault.
REQ-003 SHALL have parameter MAX_REOPEN, default 3, obstruction reversals per close cycle before alarm.
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port person_detected  in  1  presence sensor, active-high.
REQ-007 SHALL have port door_opened  in  1  fully-open limit switch.
REQ-008 SHALL have port door_closed  in  1  fully-closed limit switch.
REQ-009 SHALL have port mode  in  2  00 AUTO, 01 LOCK_OPEN, 10 LOCK_CLOSED, 11 treated as AUTO.
REQ-010 SHALL have port fault_clr  in  1  clears FAULT, ignored in all other states.
REQ-011 SHALL have ports mo, mc, ms  out  1 each  motor open / close / stop, registered.
REQ-012 SHALL have port fault  out  1  registered, high exactly while in FAULT.
REQ-013 SHALL have port obstr_alarm  out  1  sticky obstruction alarm.
REQ-014 SHALL have port state_o  out  3  current state encoding.

Function
REQ-015 States: IDLE, OPENING, OPEN, CLOSING, STOP, FAULT; mo/mc/ms mutually exclusive, updated on the same edge as the transition.
REQ-016 IDLE: (AUTO and person_detected and door_closed) or LOCK_OPEN -> OPENING, mo=1, travel counter cleared; LOCK_CLOSED stays IDLE regardless of person.
REQ-017 OPENING: door_opened -> OPEN, mo=0, hold counter loaded with HOLD_CYCLES.
REQ-018 OPEN: person_detected (mode not LOCK_CLOSED) reloads hold to HOLD_CYCLES; else hold>0 decrements; hold==0 and no person and mode!=LOCK_OPEN -> CLOSING, mc=1, travel counter cleared.
REQ-019 OPEN in LOCK_OPEN: remains OPEN indefinitely, motors off; in LOCK_CLOSED: person ignored, hold counts down to close.
REQ-020 CLOSING: person_detected -> STOP, ms=1, reopen count +1 (saturating); else door_closed -> IDLE, mc=0, reopen count cleared, obstr_alarm cleared; person has priority over door_closed on the same cycle.
REQ-021 CLOSING with mode LOCK_OPEN -> OPENING, mo=1, reopen count unchanged.
REQ-022 STOP: minimum one cycle; !person_detected -> OPENING, mo=1; if reopen count == MAX_REOPEN on that exit, obstr_alarm set to 1.
REQ-023 Travel counter increments each cycle in OPENING/CLOSING; reaching TRAVEL_TIMEOUT before the target switch -> FAULT.
REQ-024 door_opened and door_closed both high in any non-FAULT state -> FAULT (sensor conflict), overriding all other transitions.
REQ-025 FAULT: mo=0, mc=0, ms=1, fault=1; fault_clr -> IDLE, ms=0, fault=0, all counters cleared.
REQ-026 Counter widths: $clog2(P+1) for each parameter P; no wrap, hold and reopen counters saturate.
REQ-027 Illegal state encoding -> IDLE, all motor outputs 0.

Reset
REQ-028 rst low asynchronously forces IDLE, mo=mc=ms=0, fault=0, obstr_alarm=0, all counters 0, including mid-travel.
REQ-029 First transition evaluated on the first rising clk edge after rst deasserts.

Structure
REQ-030 Shared package door_pkg SHALL hold state encodings and mode constants (MODE_AUTO, MODE_LOCK_OPEN, MODE_LOCK_CLOSED).
REQ-031 One sub-module door_timer (loadable, saturating down/up counter, parametrised width) SHALL be instantiated for hold and travel timing.

Verification (HOLD_CYCLES=4, TRAVEL_TIMEOUT=8, MAX_REOPEN=2)
REQ-032 AUTO, door_closed=1, person pulse -> mo=1 next edge; door_opened at cycle 5 -> OPEN; no person -> mc=1 exactly 5 edges later; door_closed -> IDLE, all motors 0.
REQ-033 Person re-asserted at hold=1 in OPEN -> hold reloads to 4, CLOSING delayed by 5 further cycles.
REQ-034 Three obstructions during CLOSING -> ms pulses each time, obstr_alarm=1 after 2nd STOP exit, cleared on door_closed.
REQ-035 OPENING with door_opened never asserted -> FAULT after 8 cycles, ms=1, fault=1; fault_clr -> IDLE next edge.
REQ-036 door_opened=door_closed=1 in OPEN -> FAULT next edge; rst low mid-CLOSING -> immediate IDLE, outputs 0.
REQ-037 LOCK_OPEN asserted during CLOSING -> OPENING next edge, then OPEN held with person absent for 20 cycles.
